// File: rtl/cr_register_file_pkg.sv
// ============================================================================
// Package : cr_register_file_pkg
// Purpose : Shared condition-register types and constants for the CR rename
//           register file and its per-field slots.
// Contents: CR_FIELDS   - number of 4-bit CR fields
//           CR_FIELD_W  - width of one CR field
//           cr_field_t  - one CR field, bit 0 is the MSB (big-endian numbering)
//           popcount8   - number of set bits in an 8-bit vector
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package cr_register_file_pkg;

  localparam int CR_FIELDS  = 8;
  localparam int CR_FIELD_W = 4;

  typedef logic [0:3] cr_field_t;

  function automatic logic [3:0] popcount8(input logic [0:7] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cr_register_file_slot.sv
// ============================================================================
// Module  : cr_field_slot
// Purpose : One CR field of the rename register file. Holds the field value,
//           its busy bit and the producer tag, performs the write-back tag
//           compare and flags write-backs that are rejected.
// Ports   : clk, rst          - clock, synchronous active-high reset
//           alloc_i           - this field is claimed by dispatch this cycle
//           alloc_rs_id_i     - producer ID for the claim
//           flush_i           - clear busy (tag and value retained)
//           wb_wr_i           - qualified write-back write to this field
//           wb_rs_id_i        - producer ID carried by the write-back
//           wb_data_i         - write-back field data
//           value_o/busy_o/tag_o - field state for dispatch
//           reject_o          - write-back to this field was dropped
// Config  : CR_BYPASS_EN - value_o/busy_o show a committing write-back in
//           the same cycle; registered state is unaffected.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cr_field_slot
  import cr_register_file_pkg::*;
#(
  parameter int RS_ID_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alloc_i,
  input  logic [RS_ID_WIDTH-1:0] alloc_rs_id_i,
  input  logic                   flush_i,
  input  logic                   wb_wr_i,
  input  logic [RS_ID_WIDTH-1:0] wb_rs_id_i,
  input  cr_field_t              wb_data_i,
  output cr_field_t              value_o,
  output logic                   busy_o,
  output logic [RS_ID_WIDTH-1:0] tag_o,
  output logic                   reject_o
);

  cr_field_t              value_q, value_d;
  logic                   busy_q,  busy_d;
  logic [RS_ID_WIDTH-1:0] tag_q,   tag_d;
  logic                   commit;

  // Compare uses the pre-flush busy/tag, so a write-back racing a flush
  // can still land.
  assign commit   = wb_wr_i & busy_q & (wb_rs_id_i == tag_q);
  assign reject_o = wb_wr_i & ~commit;

  always_comb begin
    value_d = value_q;
    busy_d  = busy_q;
    tag_d   = tag_q;
    if (commit) begin
      value_d = wb_data_i;
      busy_d  = 1'b0;
    end
    if (flush_i) begin
      busy_d = 1'b0;
    end
    // A same-cycle claim is ordered after commit and flush.
    if (alloc_i) begin
      busy_d = 1'b1;
      tag_d  = alloc_rs_id_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= '0;
      busy_q  <= 1'b0;
      tag_q   <= '0;
    end else begin
      value_q <= value_d;
      busy_q  <= busy_d;
      tag_q   <= tag_d;
    end
  end

`ifdef CR_BYPASS_EN
  logic show_commit;
  // Reset dominates, so nothing is forwarded while it is asserted.
  assign show_commit = commit & ~rst;
  assign value_o     = show_commit ? wb_data_i : value_q;
  assign busy_o      = show_commit ? alloc_i   : busy_q;
`else
  assign value_o = value_q;
  assign busy_o  = busy_q;
`endif
  assign tag_o = tag_q;

endmodule

`default_nettype wire

// File: rtl/cr_register_file.sv
// ============================================================================
// Module  : cr_register_file
// Purpose : Architected condition register (8 x 4-bit fields) with per-field
//           rename tags. Dispatch tags fields with the producing RS ID; a
//           write-back commits a field only when its RS ID matches the tag.
//           Rejected field writes are counted in a saturating counter.
// Ports   : clk, rst (sync, active-high)
//           alloc_valid/alloc_enable/alloc_rs_id - dispatch claims
//           flush                                 - clear all busy bits
//           wb_valid/wb_rs_id/wb_enable/wb_result - arbiter CR write-back
//           cr_value/cr_busy/cr_tag               - field state out
//           stale_drop_cnt                        - rejected write count
// Config  : CR_BYPASS_EN - forward committing write-back data to cr_value
//           and cr_busy in the same cycle.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cr_register_file
  import cr_register_file_pkg::*;
#(
  parameter int RS_ID_WIDTH = 5,
  parameter int DROP_CNT_W  = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        alloc_valid,
  input  logic [0:7]                  alloc_enable,
  input  logic [RS_ID_WIDTH-1:0]      alloc_rs_id,
  input  logic                        flush,
  input  logic                        wb_valid,
  input  logic [0:7][RS_ID_WIDTH-1:0] wb_rs_id,
  input  logic [0:7]                  wb_enable,
  input  logic [0:31]                 wb_result,
  output logic [0:31]                 cr_value,
  output logic [0:7]                  cr_busy,
  output logic [0:7][RS_ID_WIDTH-1:0] cr_tag,
  output logic [DROP_CNT_W-1:0]       stale_drop_cnt
);

  logic [0:7]            reject;
  logic [3:0]            reject_cnt;
  logic [DROP_CNT_W:0]   drop_sum;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  for (genvar i = 0; i < CR_FIELDS; i++) begin : g_slot
    cr_field_slot #(
      .RS_ID_WIDTH(RS_ID_WIDTH)
    ) u_slot (
      .clk          (clk),
      .rst          (rst),
      .alloc_i      (alloc_valid & alloc_enable[i]),
      .alloc_rs_id_i(alloc_rs_id),
      .flush_i      (flush),
      .wb_wr_i      (wb_valid & wb_enable[i]),
      .wb_rs_id_i   (wb_rs_id[i]),
      .wb_data_i    (wb_result[CR_FIELD_W*i +: CR_FIELD_W]),
      .value_o      (cr_value[CR_FIELD_W*i +: CR_FIELD_W]),
      .busy_o       (cr_busy[i]),
      .tag_o        (cr_tag[i]),
      .reject_o     (reject[i])
    );
  end

  // One extra bit of headroom: its carry-out means the counter would wrap.
  assign reject_cnt = popcount8(reject);
  assign drop_sum   = {1'b0, drop_cnt_q} + {{(DROP_CNT_W-3){1'b0}}, reject_cnt};

  always_comb begin
    drop_cnt_d = drop_sum[DROP_CNT_W-1:0];
    if (drop_sum[DROP_CNT_W]) begin
      drop_cnt_d = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign stale_drop_cnt = drop_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_cr_register_file.sv
// ============================================================================
// Module  : tb_cr_register_file
// Purpose : Self-checking bench for cr_register_file. A driver issues one
//           stimulus vector per cycle, pushes the expected outputs for that
//           cycle onto a scoreboard and advances a field-level reference
//           model; a monitor pops and compares on every falling edge.
//           Directed scenarios are also checked against fixed values.
// Config  : CR_BYPASS_EN - expectations include same-cycle forwarding.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cr_register_file;

  localparam int RW  = 5;
  localparam int CW  = 16;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              alloc_valid;
  logic [0:7]        alloc_enable;
  logic [RW-1:0]     alloc_rs_id;
  logic              flush;
  logic              wb_valid;
  logic [0:7][RW-1:0] wb_rs_id;
  logic [0:7]        wb_enable;
  logic [0:31]       wb_result;
  logic [0:31]       cr_value;
  logic [0:7]        cr_busy;
  logic [0:7][RW-1:0] cr_tag;
  logic [CW-1:0]     stale_drop_cnt;

  always #5 clk = ~clk;

  cr_register_file #(
    .RS_ID_WIDTH(RW),
    .DROP_CNT_W (CW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .alloc_valid   (alloc_valid),
    .alloc_enable  (alloc_enable),
    .alloc_rs_id   (alloc_rs_id),
    .flush         (flush),
    .wb_valid      (wb_valid),
    .wb_rs_id      (wb_rs_id),
    .wb_enable     (wb_enable),
    .wb_result     (wb_result),
    .cr_value      (cr_value),
    .cr_busy       (cr_busy),
    .cr_tag        (cr_tag),
    .stale_drop_cnt(stale_drop_cnt)
  );

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [0:31]        value;
    logic [0:7]         busy;
    logic [0:7][RW-1:0] tag;
    logic [CW-1:0]      cnt;
  } exp_t;

  exp_t sb_q[$];

  // Reference model: one entry per CR field plus the drop count.
  logic [3:0]    m_val [8];
  bit            m_busy[8];
  logic [RW-1:0] m_tag [8];
  int unsigned   m_cnt;

  // Stimulus for the next cycle.
  logic               s_rst, s_av, s_fl, s_wv;
  logic [0:7]         s_ae, s_we;
  logic [RW-1:0]      s_aid;
  logic [0:7][RW-1:0] s_wid;
  logic [0:31]        s_wr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic bit wb_hits(input int i);
    return s_wv && s_we[i] && m_busy[i] && (s_wid[i] == m_tag[i]);
  endfunction

  function automatic exp_t model_view();
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      e.value[4*i +: 4] = m_val[i];
      e.busy[i]         = m_busy[i];
      e.tag[i]          = m_tag[i];
`ifdef CR_BYPASS_EN
      if (!s_rst && wb_hits(i)) begin
        e.value[4*i +: 4] = s_wr[4*i +: 4];
        e.busy[i]         = s_av && s_ae[i];
      end
`endif
    end
    e.cnt = m_cnt[CW-1:0];
    return e;
  endfunction

  task automatic model_step();
    int  rejects;
    bit  hit;
    if (s_rst) begin
      for (int i = 0; i < 8; i++) begin
        m_val[i] = '0; m_busy[i] = 0; m_tag[i] = '0;
      end
      m_cnt = 0;
    end else begin
      rejects = 0;
      for (int i = 0; i < 8; i++) begin
        hit = wb_hits(i);
        if (hit) m_val[i] = s_wr[4*i +: 4];
        if (s_wv && s_we[i] && !hit) rejects++;
        if (s_fl || hit) m_busy[i] = 0;
        if (s_av && s_ae[i]) begin
          m_busy[i] = 1;
          m_tag[i]  = s_aid;
        end
      end
      m_cnt = (m_cnt + rejects > CNT_MAX) ? CNT_MAX : m_cnt + rejects;
    end
  endtask

  task automatic clear_stim();
    s_rst = 0; s_av = 0; s_fl = 0; s_wv = 0;
    s_ae = '0; s_we = '0; s_aid = '0; s_wid = '0; s_wr = '0;
  endtask

  // Apply the staged stimulus for one cycle and record its expectation.
  task automatic step(input bit push);
    @(posedge clk);
    #1;
    rst          = s_rst;
    alloc_valid  = s_av;
    alloc_enable = s_ae;
    alloc_rs_id  = s_aid;
    flush        = s_fl;
    wb_valid     = s_wv;
    wb_enable    = s_we;
    wb_rs_id     = s_wid;
    wb_result    = s_wr;
    if (push) sb_q.push_back(model_view());
    model_step();
    clear_stim();
  endtask

  exp_t mon_e;
  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      mon_e = sb_q.pop_front();
      check("sb_value", 64'(cr_value),       64'(mon_e.value));
      check("sb_busy",  64'(cr_busy),        64'(mon_e.busy));
      check("sb_tag",   64'(cr_tag),         64'(mon_e.tag));
      check("sb_cnt",   64'(stale_drop_cnt), 64'(mon_e.cnt));
    end
  end

  initial begin
    clear_stim();
    rst = 1; alloc_valid = 0; alloc_enable = '0; alloc_rs_id = '0; flush = 0;
    wb_valid = 0; wb_enable = '0; wb_rs_id = '0; wb_result = '0;
    for (int i = 0; i < 8; i++) begin
      m_val[i] = '0; m_busy[i] = 0; m_tag[i] = '0;
    end
    m_cnt = 0;

    s_rst = 1; step(0);
    s_rst = 1; step(0);
    step(1);
    @(negedge clk);
    check("reset_value", 64'(cr_value), 64'h0);
    check("reset_busy",  64'(cr_busy),  64'h0);
    check("reset_cnt",   64'(stale_drop_cnt), 64'h0);

    // 1: alloc field 0 tag 5, matching write-back 0100.
    s_av = 1; s_ae = 8'b1000_0000; s_aid = 5; step(1);
    s_wv = 1; s_we = 8'b1000_0000; s_wid[0] = 5; s_wr = 32'h4000_0000; step(1);
`ifdef CR_BYPASS_EN
    @(negedge clk);
    check("t1_bypass_value", 64'(cr_value[0:3]), 64'h4);
    check("t1_bypass_busy",  64'(cr_busy[0]),    64'h0);
`endif
    step(1);
    @(negedge clk);
    check("t1_value", 64'(cr_value[0:3]), 64'h4);
    check("t1_busy",  64'(cr_busy[0]),    64'h0);

    // 2: stale write-back after re-allocation is dropped.
    s_av = 1; s_ae = 8'b0010_0000; s_aid = 3; step(1);
    s_av = 1; s_ae = 8'b0010_0000; s_aid = 7; step(1);
    s_wv = 1; s_we = 8'b0010_0000; s_wid[2] = 3; s_wr = 32'h00F0_0000; step(1);
    step(1);
    @(negedge clk);
    check("t2_value", 64'(cr_value[8:11]), 64'h0);
    check("t2_busy",  64'(cr_busy[2]),     64'h1);
    check("t2_tag",   64'(cr_tag[2]),      64'h7);
    check("t2_cnt",   64'(stale_drop_cnt), 64'h1);

    // 3: all fields written at once.
    s_av = 1; s_ae = 8'hFF; s_aid = 9; step(1);
    s_wv = 1; s_we = 8'hFF; for (int i = 0; i < 8; i++) s_wid[i] = 9;
    s_wr = 32'h1234_5678; step(1);
    step(1);
    @(negedge clk);
    check("t3_value", 64'(cr_value), 64'h1234_5678);
    check("t3_busy",  64'(cr_busy),  64'h0);

    // 4: same-cycle alloc and matching write-back on field 1.
    s_av = 1; s_ae = 8'b0100_0000; s_aid = 2; step(1);
    s_av = 1; s_ae = 8'b0100_0000; s_aid = 4;
    s_wv = 1; s_we = 8'b0100_0000; s_wid[1] = 2; s_wr = 32'h0800_0000; step(1);
    step(1);
    @(negedge clk);
    check("t4_value", 64'(cr_value[4:7]), 64'h8);
    check("t4_busy",  64'(cr_busy[1]),    64'h1);
    check("t4_tag",   64'(cr_tag[1]),     64'h4);

    // 5: flush with a same-cycle matching write-back on field 3.
    s_av = 1; s_ae = 8'b0001_1000; s_aid = 6; step(1);
    s_fl = 1; s_wv = 1; s_we = 8'b0001_0000; s_wid[3] = 6; s_wr = 32'h000A_0000; step(1);
    step(1);
    @(negedge clk);
    check("t5_value", 64'(cr_value[12:15]), 64'hA);
    check("t5_busy",  64'(cr_busy), 64'h0);

    // Randomized traffic, including occasional mid-stream reset.
    for (int k = 0; k < 600; k++) begin
      s_rst = ($urandom_range(0, 63) == 0);
      s_av  = ($urandom_range(0, 2) == 0);
      s_ae  = 8'($urandom);
      s_aid = RW'($urandom);
      s_fl  = ($urandom_range(0, 15) == 0);
      s_wv  = 1'($urandom);
      s_we  = 8'($urandom);
      s_wr  = $urandom;
      for (int i = 0; i < 8; i++)
        s_wid[i] = ($urandom_range(0, 2) != 0) ? m_tag[i] : RW'($urandom);
      step(1);
    end

    // 6: saturation, 2^CW + 3 rejected writes in total.
    s_rst = 1; step(1);
    for (int k = 0; k < 8191; k++) begin
      s_wv = 1; s_we = 8'hFF; step(1);
    end
    s_wv = 1; s_we = 8'b1111_1100; step(1);
    step(1);
    @(negedge clk);
    check("t6_below_max", 64'(stale_drop_cnt), 64'(CNT_MAX - 1));
    s_wv = 1; s_we = 8'b1111_1000; step(1);
    step(1);
    @(negedge clk);
    check("t6_saturated", 64'(stale_drop_cnt), 64'(CNT_MAX));

    repeat (3) @(posedge clk);
    if (sb_q.size() != 0) check("sb_drained", 64'(sb_q.size()), 64'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
